// File: rtl/pc_seq_4b.sv
// Four-bit program-counter sequencer: walks the select lines of a 16:1 mux under a
// fetch/execute state machine and captures the selected mux bit at the end of FETCH.
module pc_seq_4b #(
    parameter logic [3:0] RESET_PC = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stall,
    input  logic       jmp,
    input  logic [3:0] jmp_addr,
    input  logic       halt,
    input  logic       res,
    output logic       sel3,
    output logic       sel2,
    output logic       sel1,
    output logic       sel0,
    output logic       fetch,
    output logic       bit_q,
    output logic       wrap,
    output logic       halted
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] pc_r;
    logic [3:0] pc_next_s;
    logic       bit_q_r;
    logic       bit_q_next_s;
    logic       wrap_r;
    logic       wrap_next_s;
    logic       fetch_r;
    logic       halted_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; in EXEC halt outranks stall, which outranks jmp/increment
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                next_state_s = ST_EXEC;
            end
            ST_EXEC: begin
                if (halt) begin
                    next_state_s = ST_HALT;
                end else if (stall) begin
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (start) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_HALT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: PC update, captured mux bit and wrap detection
    always_comb begin
        pc_next_s    = pc_r;
        bit_q_next_s = bit_q_r;
        wrap_next_s  = 1'b0;
        case (state_r)
            ST_FETCH: begin
                bit_q_next_s = res;
            end
            ST_EXEC: begin
                if (halt || stall) begin
                    pc_next_s = pc_r;
                end else if (jmp) begin
                    pc_next_s = jmp_addr;
                end else begin
                    pc_next_s   = pc_r + 4'd1;
                    wrap_next_s = (pc_r == 4'd15);
                end
            end
            default: begin
                pc_next_s = pc_r;
            end
        endcase
    end

    // Output registers; fetch/halted follow the state being entered so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r     <= RESET_PC;
            bit_q_r  <= 1'b0;
            wrap_r   <= 1'b0;
            fetch_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            pc_r     <= pc_next_s;
            bit_q_r  <= bit_q_next_s;
            wrap_r   <= wrap_next_s;
            fetch_r  <= (next_state_s == ST_FETCH);
            halted_r <= (next_state_s == ST_HALT);
        end
    end

    assign sel3   = pc_r[3];
    assign sel2   = pc_r[2];
    assign sel1   = pc_r[1];
    assign sel0   = pc_r[0];
    assign fetch  = fetch_r;
    assign bit_q  = bit_q_r;
    assign wrap   = wrap_r;
    assign halted = halted_r;

endmodule

// File: tb/tb_pc_seq_4b.sv
// Directed bench for pc_seq_4b: a vector table plus hand-written multi-cycle sequences,
// with a 16:1 mux model feeding res from the select lines.
module tb_pc_seq_4b;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stall;
    logic        jmp;
    logic [3:0]  jmp_addr;
    logic        halt;
    logic        res;
    logic        sel3, sel2, sel1, sel0;
    logic        fetch, bit_q, wrap, halted;
    logic [15:0] mux_in;
    logic [3:0]  sel;

    int checks   = 0;
    int failures = 0;

    pc_seq_4b #(.RESET_PC(4'd0)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .jmp(jmp),
        .jmp_addr(jmp_addr), .halt(halt), .res(res),
        .sel3(sel3), .sel2(sel2), .sel1(sel1), .sel0(sel0),
        .fetch(fetch), .bit_q(bit_q), .wrap(wrap), .halted(halted)
    );

    always #5 clk = ~clk;

    assign sel = {sel3, sel2, sel1, sel0};
    assign res = mux_in[sel];

    typedef struct {
        logic       start;
        logic       stall;
        logic       jmp;
        logic [3:0] jmp_addr;
        logic       halt;
        logic [3:0] exp_sel;
        logic       exp_fetch;
        logic       exp_bitq;
        logic       exp_wrap;
        logic       exp_halted;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [3:0] e_sel, input logic e_fetch,
                         input logic e_bitq, input logic e_wrap, input logic e_halted);
        logic [7:0] act;
        logic [7:0] exp;
        act = {sel, fetch, bit_q, wrap, halted};
        exp = {e_sel, e_fetch, e_bitq, e_wrap, e_halted};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got sel=%b fetch=%b bit_q=%b wrap=%b halted=%b, expected sel=%b fetch=%b bit_q=%b wrap=%b halted=%b",
                     name, act[7:4], act[3], act[2], act[1], act[0],
                     exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; stall = 1'b0; jmp = 1'b0; jmp_addr = 4'd0; halt = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic st, input logic sl, input logic jp, input logic [3:0] ja,
                                input logic hl, input logic [3:0] es, input logic ef,
                                input logic eb, input logic ew, input logic eh);
        vec_t v;
        v.start = st; v.stall = sl; v.jmp = jp; v.jmp_addr = ja; v.halt = hl;
        v.exp_sel = es; v.exp_fetch = ef; v.exp_bitq = eb; v.exp_wrap = ew; v.exp_halted = eh;
        return v;
    endfunction

    int wraps;
    int wrap_at_zero;

    initial begin
        // Table for mux_in with only input k (index 10) set
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b1, 4'd10, 1'b0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd10, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd11, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, 1'b1, 4'd4,  1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 4'd3,  1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 4'd2,  1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[11] = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        vecs[17] = mk(1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[19] = mk(1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0);

        // Reset values
        mux_in = 16'h0400;
        idle_inputs();
        rst = 1'b1;
        #2;
        check("reset_async", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            start = vecs[i].start; stall = vecs[i].stall; jmp = vecs[i].jmp;
            jmp_addr = vecs[i].jmp_addr; halt = vecs[i].halt;
            step();
            check($sformatf("vec%0d", i), vecs[i].exp_sel, vecs[i].exp_fetch,
                  vecs[i].exp_bitq, vecs[i].exp_wrap, vecs[i].exp_halted);
        end

        // Full walk with every mux input high: 0..15,0, two cycles per PC, one wrap
        mux_in = 16'hFFFF;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        wraps = 0;
        wrap_at_zero = 0;
        for (int i = 0; i <= 16; i++) begin
            if (wrap) begin
                wraps++;
                if (sel == 4'd0 && i == 16) wrap_at_zero++;
            end
            check($sformatf("walk_fetch%0d", i), i[3:0], 1'b1, (i == 0) ? 1'b0 : 1'b1,
                  (i == 16) ? 1'b1 : 1'b0, 1'b0);
            step();
            if (wrap) wraps++;
            check($sformatf("walk_exec%0d", i), i[3:0], 1'b0, 1'b1, 1'b0, 1'b0);
            step();
        end
        checks++;
        if (wraps != 1 || wrap_at_zero != 1) begin
            failures++;
            $display("FAIL walk_wrap_count: got %0d pulses (%0d at sel 0), expected 1", wraps, wrap_at_zero);
        end

        // Stall for 3 cycles at PC 5: bit_q holds even when res changes
        mux_in = 16'h0020;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        jmp = 1'b1; jmp_addr = 4'd5;
        step();
        jmp = 1'b0;
        step();
        check("stall_exec0", 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        stall = 1'b1;
        mux_in = 16'h0000;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("stall_exec%0d", i), 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        stall = 1'b0;
        step();
        check("stall_release", 4'd6, 1'b1, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-FETCH at PC 9
        mux_in = 16'h0001;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        jmp = 1'b1; jmp_addr = 4'd9;
        step();
        jmp = 1'b0;
        check("pre_reset_fetch9", 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_fetch", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();
        step();
        check("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_fetch", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("restart_exec", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
